// File: rtl/risc_v_mike_uart_rx.sv
// UART receiver: 1 start, DATA_W data bits (LSB first), 1 even-parity bit, 1 stop.
// Deserialises the asynchronous rx pin into rx_data/rx_flag/parity_error for the
// UART register block. All state is on the rising edge of clk with synchronous reset.
module risc_v_mike_uart_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              rx_flag_clr,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_flag,
  output logic              parity_error,
  output logic              rx_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int H     = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] sh;
  logic              p_err;
  logic              rx_meta;
  logic              rx_s;

  // Two-flop synchroniser; both flops reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM with registered outputs; a valid stop's flag set overrides a same-edge clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      sh           <= '0;
      p_err        <= 1'b0;
      rx_data      <= '0;
      rx_flag      <= 1'b0;
      parity_error <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      if (rx_flag_clr) begin
        rx_flag <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            cnt     <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            sh  <= {rx_s, sh[DATA_W-1:1]};
            if (idx == IDX_LAST) begin
              state <= PARITY;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            p_err <= rx_s ^ (^sh);
            state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data      <= sh;
              parity_error <= p_err;
              rx_flag      <= 1'b1;
              state        <= IDLE;
              rx_busy      <= 1'b0;
            end else begin
              state <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc_v_mike_uart_rx.sv
// Directed testbench for risc_v_mike_uart_rx with CLKS_PER_BIT=16 (H=8), DATA_W=8.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_risc_v_mike_uart_rx;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rx_flag_clr;
  logic [7:0] rx_data;
  logic       rx_flag;
  logic       parity_error;
  logic       rx_busy;

  int tests_run;
  int tests_failed;

  risc_v_mike_uart_rx #(
    .DATA_W       (8),
    .CLKS_PER_BIT (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_flag_clr  (rx_flag_clr),
    .rx_data      (rx_data),
    .rx_flag      (rx_flag),
    .parity_error (parity_error),
    .rx_busy      (rx_busy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports a failure with observed/expected values.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives start, data (LSB first) and parity for 16 clk each, then sets the stop
  // level and returns at the falling edge just before the stop-sample edge.
  task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (16) @(negedge clk);
    end
    rx = par;
    repeat (16) @(negedge clk);
    rx = stop;
    repeat (10) @(negedge clk);
  endtask

  // Linear sequence of directed steps.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    rx           = 1'b1;
    rx_flag_clr  = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    checkOutput("reset_data", 32'(rx_data), 32'h00);
    checkOutput("reset_flag", 32'(rx_flag), 32'h0);
    checkOutput("reset_perr", 32'(parity_error), 32'h0);
    checkOutput("reset_busy", 32'(rx_busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_busy", 32'(rx_busy), 32'h0);
    repeat (4) @(negedge clk);

    // Good frame 0xA5, even parity 0.
    applyStimulus(8'hA5, 1'b0, 1'b1);
    checkOutput("a5_busy_before_stop", 32'(rx_busy), 32'h1);
    checkOutput("a5_flag_before_stop", 32'(rx_flag), 32'h0);
    checkOutput("a5_data_before_stop", 32'(rx_data), 32'h00);
    @(negedge clk);
    checkOutput("a5_data", 32'(rx_data), 32'hA5);
    checkOutput("a5_flag", 32'(rx_flag), 32'h1);
    checkOutput("a5_perr", 32'(parity_error), 32'h0);
    checkOutput("a5_busy_after_stop", 32'(rx_busy), 32'h0);
    repeat (5) @(negedge clk);

    // Single-cycle clear pulse.
    rx_flag_clr = 1'b1;
    @(negedge clk);
    rx_flag_clr = 1'b0;
    checkOutput("clr_pulse_flag", 32'(rx_flag), 32'h0);
    checkOutput("clr_pulse_data", 32'(rx_data), 32'hA5);
    repeat (3) @(negedge clk);

    // Bad parity: 0x01 needs parity 1, send 0.
    applyStimulus(8'h01, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("badpar_data", 32'(rx_data), 32'h01);
    checkOutput("badpar_flag", 32'(rx_flag), 32'h1);
    checkOutput("badpar_perr", 32'(parity_error), 32'h1);
    repeat (5) @(negedge clk);
    repeat (4) @(negedge clk);

    // Glitch: rx low for 3 clk; START aborts at E0+8.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("glitch_busy_start", 32'(rx_busy), 32'h1);
    repeat (5) @(negedge clk);
    checkOutput("glitch_busy_before_abort", 32'(rx_busy), 32'h1);
    @(negedge clk);
    checkOutput("glitch_busy_after_abort", 32'(rx_busy), 32'h0);
    checkOutput("glitch_data", 32'(rx_data), 32'h01);
    checkOutput("glitch_flag", 32'(rx_flag), 32'h1);
    checkOutput("glitch_perr", 32'(parity_error), 32'h1);
    repeat (4) @(negedge clk);

    // Framing error: 0x5A with stop=0, line held low 40 clk from stop start.
    applyStimulus(8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("frame_err_data", 32'(rx_data), 32'h01);
    checkOutput("frame_err_flag", 32'(rx_flag), 32'h1);
    checkOutput("frame_err_perr", 32'(parity_error), 32'h1);
    checkOutput("frame_err_busy", 32'(rx_busy), 32'h1);
    repeat (29) @(negedge clk);
    checkOutput("wait_idle_busy", 32'(rx_busy), 32'h1);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("wait_idle_exit_busy", 32'(rx_busy), 32'h0);
    repeat (4) @(negedge clk);

    // Good 0x3C after the framing error.
    applyStimulus(8'h3C, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("recover_data", 32'(rx_data), 32'h3C);
    checkOutput("recover_flag", 32'(rx_flag), 32'h1);
    checkOutput("recover_perr", 32'(parity_error), 32'h0);
    repeat (5) @(negedge clk);

    // Clear held high through a frame: flag is a one-cycle pulse.
    rx_flag_clr = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("held_clr_flag_idle", 32'(rx_flag), 32'h0);
    applyStimulus(8'h80, 1'b1, 1'b1);
    checkOutput("held_clr_flag_before", 32'(rx_flag), 32'h0);
    @(negedge clk);
    checkOutput("held_clr_flag_pulse", 32'(rx_flag), 32'h1);
    checkOutput("held_clr_data", 32'(rx_data), 32'h80);
    checkOutput("held_clr_perr", 32'(parity_error), 32'h0);
    @(negedge clk);
    checkOutput("held_clr_flag_after", 32'(rx_flag), 32'h0);
    rx_flag_clr = 1'b0;
    repeat (8) @(negedge clk);

    // Reset asserted at E0+50 of a frame.
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (36) @(negedge clk);
    checkOutput("midframe_busy", 32'(rx_busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_data", 32'(rx_data), 32'h00);
    checkOutput("midrst_flag", 32'(rx_flag), 32'h0);
    checkOutput("midrst_perr", 32'(parity_error), 32'h0);
    checkOutput("midrst_busy", 32'(rx_busy), 32'h0);
    repeat (20) @(negedge clk);
    checkOutput("midrst_idle_busy", 32'(rx_busy), 32'h0);

    // Frame after mid-frame reset.
    applyStimulus(8'h96, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("after_rst_data", 32'(rx_data), 32'h96);
    checkOutput("after_rst_flag", 32'(rx_flag), 32'h1);
    checkOutput("after_rst_perr", 32'(parity_error), 32'h0);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
